// File: rtl/dircc_packet_tx.sv
// DiRCC packet transmitter: stamps a 240-bit packet with the local Lamport
// clock and streams it out as eight 32-bit Avalon-ST beats.
module dircc_packet_tx #(
  parameter bit STAMP_LAMPORT = 1'b1,
  parameter int BEAT_W        = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [239:0]      in_packet,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic [1:0]        out_empty,
  input  logic              rx_lamport_valid,
  input  logic [31:0]       rx_lamport,
  output logic [31:0]       lamport_now,
  output logic [31:0]       tx_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state, state_nx;
  logic [2:0]   beat, beat_nx;
  logic [239:0] held;
  logic [255:0] padded;
  logic         accept;
  logic         last_xfer;
  logic [31:0]  base;
  logic [31:0]  stamp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      beat  <= 3'd0;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    beat_nx   = beat;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    last_xfer = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = SEND;
          beat_nx  = 3'd0;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (beat == 3'd7) begin
            // Final beat leaves: a new packet may enter in the same cycle
            in_ready  = 1'b1;
            last_xfer = 1'b1;
            beat_nx   = 3'd0;
            state_nx  = in_valid ? SEND : IDLE;
          end else begin
            beat_nx = beat + 3'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        beat_nx  = 3'd0;
      end
    endcase
  end

  assign accept = in_valid && in_ready;

  // Beat k sits at bit 32*(7-k) of the padded packet; ~beat gives 7-k
  assign padded   = {held, 16'h0000};
  assign out_data = out_valid ? padded[{~beat, 5'b0} +: BEAT_W] : '0;
  assign out_sop  = out_valid && (beat == 3'd0);
  assign out_eop  = out_valid && (beat == 3'd7);
  assign out_empty = out_eop ? 2'd2 : 2'd0;

  assign base = (rx_lamport_valid && (rx_lamport > lamport_now))
              ? rx_lamport : lamport_now;
  assign stamp = STAMP_LAMPORT ? lamport_now : in_packet[127:96];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held        <= '0;
      lamport_now <= 32'd0;
      tx_count    <= 32'd0;
    end else begin
      if (accept)
        held <= {in_packet[239:128], stamp, in_packet[95:0]};
      if (accept || rx_lamport_valid)
        lamport_now <= base + 32'd1;
      if (last_xfer)
        tx_count <= tx_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dircc_packet_tx.sv
// Bench for dircc_packet_tx: queue-based beat scoreboard plus Lamport model,
// directed scenarios followed by randomized traffic.
module tb_dircc_packet_tx;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [239:0] in_packet;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_sop;
  logic         out_eop;
  logic [1:0]   out_empty;
  logic         rx_lamport_valid;
  logic [31:0]  rx_lamport;
  logic [31:0]  lamport_now;
  logic [31:0]  tx_count;

  logic [239:0] z_in_packet;
  logic         z_in_valid;
  logic         z_in_ready;
  logic [31:0]  z_out_data;
  logic         z_out_valid;
  logic         z_out_sop;
  logic         z_out_eop;
  logic [1:0]   z_out_empty;
  logic [31:0]  z_lamport_now;
  logic [31:0]  z_tx_count;

  always #5 clk = ~clk;

  dircc_packet_tx #(.STAMP_LAMPORT(1'b1), .BEAT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_packet(in_packet), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .out_empty(out_empty),
    .rx_lamport_valid(rx_lamport_valid), .rx_lamport(rx_lamport),
    .lamport_now(lamport_now), .tx_count(tx_count)
  );

  dircc_packet_tx #(.STAMP_LAMPORT(1'b0), .BEAT_W(32)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .in_packet(z_in_packet), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .out_data(z_out_data), .out_valid(z_out_valid), .out_ready(1'b1),
    .out_sop(z_out_sop), .out_eop(z_out_eop), .out_empty(z_out_empty),
    .rx_lamport_valid(1'b0), .rx_lamport(32'd0),
    .lamport_now(z_lamport_now), .tx_count(z_tx_count)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       q[$];
  logic [31:0] seen[$];
  logic [31:0] m_lam;
  logic [31:0] m_tx;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Lamport field of the n-th packet recorded in seen[], spread over beats 3 and 4
  function automatic logic [31:0] seen_stamp(input int n);
    logic [31:0] a, b;
    a = seen[8*n+3];
    b = seen[8*n+4];
    return {a[15:0], b[31:16]};
  endfunction

  task automatic push_packet(input logic [239:0] pkt_in,
                             input logic [31:0] lam);
    logic [239:0] pkt;
    logic [255:0] pad, sh;
    beat_t        b;
    pkt = pkt_in;
    pkt[127:96] = lam;
    pad = {pkt, 16'h0000};
    for (int k = 0; k < 8; k++) begin
      sh = pad >> (224 - 32 * k);
      b.data = sh[31:0];
      b.sop  = (k == 0);
      b.eop  = (k == 7);
      q.push_back(b);
    end
  endtask

  // One cycle: check outputs at negedge against the model, advance model
  task automatic tick();
    logic  exp_rdy, acc, xfer;
    logic [31:0] nxt;
    beat_t b;
    @(negedge clk);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
    xfer    = (q.size() != 0) && out_ready;
    acc     = in_valid && exp_rdy;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("lamport_now", lamport_now, m_lam);
    chk("tx_count", tx_count, m_tx);
    if (q.size() != 0) begin
      b = q[0];
      chk("out_data", out_data, b.data);
      chk("out_sop", out_sop, b.sop);
      chk("out_eop", out_eop, b.eop);
      chk("out_empty", out_empty, b.eop ? 2'd2 : 2'd0);
    end
    if (xfer) begin
      seen.push_back(out_data);
      b = q.pop_front();
      if (b.eop) m_tx++;
    end
    if (acc) push_packet(in_packet, m_lam);
    nxt = m_lam;
    if (rx_lamport_valid && rx_lamport > nxt) nxt = rx_lamport;
    if (acc || rx_lamport_valid) m_lam = nxt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rx_lamport_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    chk("drain", q.size(), 0);
  endtask

  function automatic logic [239:0] rnd_pkt();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r[239:0];
  endfunction

  initial begin
    logic [239:0] zp;
    logic [255:0] zpad, zsh;
    logic [31:0]  zb[8];
    int           acc_n;

    reset_n = 1'b0;
    in_packet = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rx_lamport_valid = 1'b0;
    rx_lamport = '0;
    z_in_packet = '0;
    z_in_valid = 1'b0;
    m_lam = 0;
    m_tx = 0;

    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst sop_eop", {out_sop, out_eop}, 0);
    chk("rst out_empty", out_empty, 0);
    chk("rst lamport", lamport_now, 0);
    chk("rst tx_count", tx_count, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single packet, stamped with 0
    seen.delete();
    in_packet = {56'hDEADBEEF_112233, 56'h44556677_8899AA,
                 32'h5555AAAA, 96'h0123456789ABCDEF0011CDEF};
    in_valid = 1'b1;
    tick();
    drain();
    chk("single beat0", seen[0], 32'hDEADBEEF);
    chk("single beat7", seen[7], 32'hCDEF0000);
    chk("single stamp", seen_stamp(0), 32'd0);
    chk("single lamport", lamport_now, 32'd1);
    chk("single tx", tx_count, 32'd1);

    // Backpressure pattern 1,0,0 repeating
    seen.delete();
    in_packet = rnd_pkt();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int p = 0; p < 60 && q.size() != 0; p++) begin
      out_ready = (p % 3) == 0;
      tick();
    end
    drain();
    chk("bp transfers", seen.size(), 8);
    chk("bp stamp", seen_stamp(0), 32'd1);

    // Reset after beat 3
    in_packet = rnd_pkt();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst eop", out_eop, 0);
    q.delete();
    m_lam = 0;
    m_tx = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post rst tx", tx_count, 0);
    chk("post rst lamport", lamport_now, 0);

    // Back-to-back: three packets, in_valid held high
    seen.delete();
    acc_n = 0;
    in_valid = 1'b1;
    in_packet = rnd_pkt();
    for (int i = 0; i < 60 && acc_n < 3; i++) begin
      if (q.size() == 0 || q.size() == 1) begin
        tick();
        acc_n++;
        in_packet = rnd_pkt();
      end else begin
        tick();
      end
    end
    drain();
    chk("b2b transfers", seen.size(), 24);
    chk("b2b stamp0", seen_stamp(0), 32'd0);
    chk("b2b stamp1", seen_stamp(1), 32'd1);
    chk("b2b stamp2", seen_stamp(2), 32'd2);
    chk("b2b sop", seen[8], seen.size() > 8 ? seen[8] : 32'hX);

    // Lamport merge
    rx_lamport_valid = 1'b1;
    rx_lamport = 32'd4;
    tick();
    rx_lamport_valid = 1'b0;
    tick();
    chk("merge 5", lamport_now, 32'd5);
    rx_lamport_valid = 1'b1;
    rx_lamport = 32'd100;
    tick();
    rx_lamport_valid = 1'b0;
    tick();
    chk("merge 101", lamport_now, 32'd101);
    seen.delete();
    in_packet = rnd_pkt();
    in_valid = 1'b1;
    rx_lamport_valid = 1'b1;
    rx_lamport = 32'd50;
    tick();
    drain();
    chk("merge stamp", seen_stamp(0), 32'd101);
    chk("merge 102", lamport_now, 32'd102);
    rx_lamport_valid = 1'b1;
    rx_lamport = 32'hFFFFFFFE;
    tick();
    rx_lamport_valid = 1'b0;
    tick();
    chk("wrap max", lamport_now, 32'hFFFFFFFF);
    in_packet = rnd_pkt();
    in_valid = 1'b1;
    tick();
    drain();
    chk("wrap zero", lamport_now, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 3) != 0;
      rx_lamport_valid = $urandom_range(0, 4) == 0;
      rx_lamport = $urandom_range(0, 1) ? m_lam + $urandom_range(0, 20)
                                        : $urandom;
      in_packet = rnd_pkt();
      tick();
    end
    drain();

    // Pass-through instance: lamport field kept, clock still advances
    zp = {56'hA1A2A3A4_A5A6A7, 56'hB1B2B3B4_B5B6B7,
          32'hCAFEF00D, 96'h0F0E0D0C0B0A090807060504};
    z_in_packet = zp;
    z_in_valid = 1'b1;
    @(negedge clk);
    chk("z in_ready", z_in_ready, 1);
    @(posedge clk);
    #1;
    z_in_valid = 1'b0;
    zpad = {zp, 16'h0000};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      zsh = zpad >> (224 - 32 * k);
      zb[k] = z_out_data;
      chk("z out_data", z_out_data, zsh[31:0]);
      chk("z sop_eop", {z_out_sop, z_out_eop}, {k == 0, k == 7});
    end
    @(negedge clk);
    chk("z lamport field", {zb[3][15:0], zb[4][31:16]}, 32'hCAFEF00D);
    chk("z lamport_now", z_lamport_now, 32'd1);
    chk("z tx_count", z_tx_count, 32'd1);
    chk("z out_valid", z_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
